// File: rtl/fwrisc_mem_arb_pkg.sv
// Shared types for the fwrisc I/D memory arbiter: FSM state encoding and requester ids.
package fwrisc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    function automatic logic prio_req(input int data_priority);
        return (data_priority != 0) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/fwrisc_mem_arb_if.sv
// Bus bundle around the arbiter: core fetch port, core data port and the shared memory port.
// master = the arbiter's view (it masters the memory); slave = the core + memory side.
interface fwrisc_mem_arb_if;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        iready;

    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic        dvalid;
    logic [31:0] drdata;
    logic        dready;

    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstb;
    logic        mwrite;
    logic        mvalid;
    logic [31:0] mrdata;
    logic        mready;

    modport master (
        input  iaddr, ivalid, daddr, dwdata, dwstb, dwrite, dvalid, mrdata, mready,
        output idata, iready, drdata, dready, maddr, mwdata, mwstb, mwrite, mvalid
    );

    modport slave (
        output iaddr, ivalid, daddr, dwdata, dwstb, dwrite, dvalid, mrdata, mready,
        input  idata, iready, drdata, dready, maddr, mwdata, mwstb, mwrite, mvalid
    );
endinterface

// File: rtl/fwrisc_mem_arb_sel.sv
// Grant selection for the arbiter: fixed priority with a saturating counter that hands
// one grant to the waiting side after MAX_CONSEC back-to-back priority-side wins.
module fwrisc_mem_arb_sel
    import fwrisc_mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_CONSEC    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ivalid,
    input  logic dvalid,
    input  logic arb_en,
    output logic grant_valid,
    output logic grant_id
);

    localparam logic       PRIO = prio_req(DATA_PRIORITY);
    localparam logic [3:0] MAXC = 4'(MAX_CONSEC);

    logic [3:0] consec_q, consec_d;
    logic       prio_valid, other_valid;

    always_comb begin
        prio_valid  = (PRIO == REQ_D) ? dvalid : ivalid;
        other_valid = (PRIO == REQ_D) ? ivalid : dvalid;
        grant_valid = arb_en && (ivalid || dvalid);

        if (prio_valid && (!other_valid || consec_q != MAXC))
            grant_id = PRIO;
        else
            grant_id = ~PRIO;

        // Only contested priority wins count; anything else restarts the run.
        consec_d = consec_q;
        if (grant_valid) begin
            if (grant_id == PRIO && other_valid)
                consec_d = (consec_q == MAXC) ? consec_q : consec_q + 4'd1;
            else
                consec_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            consec_q <= '0;
        else
            consec_q <= consec_d;
    end

endmodule

// File: rtl/fwrisc_mem_arb.sv
// Shares one single-ported memory between the fwrisc fetch and data ports, one access in flight.
// Optional FWRISC_MEM_ARB_PERF_EN adds per-port wait-cycle counters.
module fwrisc_mem_arb
    import fwrisc_mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_CONSEC    = 4
) (
    input  logic              clock,
    input  logic              reset,
    fwrisc_mem_arb_if.master  bus
`ifdef FWRISC_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       i_wait_cnt,
    output logic [31:0]       d_wait_cnt
`endif
);

    arb_state_e  state_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [3:0]  mwstb_q;
    logic        mwrite_q;
    logic        mvalid_q;
    logic        grant_valid;
    logic        grant_id;

    fwrisc_mem_arb_sel #(
        .DATA_PRIORITY (DATA_PRIORITY),
        .MAX_CONSEC    (MAX_CONSEC)
    ) u_sel (
        .clock       (clock),
        .reset       (reset),
        .ivalid      (bus.ivalid),
        .dvalid      (bus.dvalid),
        .arb_en      (state_q == IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // IDLE always lasts a cycle, so a requester can never be granted back-to-back with no gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwstb_q  <= '0;
            mwrite_q <= 1'b0;
            mvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        mvalid_q <= 1'b1;
                        if (grant_id == REQ_D) begin
                            state_q  <= BUSY_D;
                            maddr_q  <= bus.daddr;
                            mwdata_q <= bus.dwdata;
                            mwstb_q  <= bus.dwstb;
                            mwrite_q <= bus.dwrite;
                        end else begin
                            state_q  <= BUSY_I;
                            maddr_q  <= bus.iaddr;
                            mwdata_q <= '0;
                            mwstb_q  <= 4'hF;
                            mwrite_q <= 1'b0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mready) begin
                        state_q  <= IDLE;
                        mvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.maddr  = maddr_q;
    assign bus.mwdata = mwdata_q;
    assign bus.mwstb  = mwstb_q;
    assign bus.mwrite = mwrite_q;
    assign bus.mvalid = mvalid_q;
    assign bus.idata  = bus.mrdata;
    assign bus.drdata = bus.mrdata;
    assign bus.iready = (state_q == BUSY_I) && bus.mready;
    assign bus.dready = (state_q == BUSY_D) && bus.mready;

`ifdef FWRISC_MEM_ARB_PERF_EN
    logic [31:0] i_wait_q;
    logic [31:0] d_wait_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            i_wait_q <= '0;
            d_wait_q <= '0;
        end else begin
            if (bus.ivalid && state_q != BUSY_I)
                i_wait_q <= i_wait_q + 32'd1;
            if (bus.dvalid && state_q != BUSY_D)
                d_wait_q <= d_wait_q + 32'd1;
        end
    end

    assign i_wait_cnt = i_wait_q;
    assign d_wait_cnt = d_wait_q;
`endif

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Self-checking bench for fwrisc_mem_arb: vector table, directed corner sequences and a
// randomized run against a transaction-level model. Honours FWRISC_MEM_ARB_PERF_EN.
module tb_fwrisc_mem_arb;

    localparam int DATA_PRIORITY = 1;
    localparam int MAX_CONSEC    = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fwrisc_mem_arb_if bus();

`ifdef FWRISC_MEM_ARB_PERF_EN
    logic [31:0] i_wait_cnt, d_wait_cnt;
`endif

    fwrisc_mem_arb #(
        .DATA_PRIORITY (DATA_PRIORITY),
        .MAX_CONSEC    (MAX_CONSEC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FWRISC_MEM_ARB_PERF_EN
        ,
        .i_wait_cnt (i_wait_cnt),
        .d_wait_cnt (d_wait_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
        logic        dwr;
        logic [31:0] rd;
        logic        expD;
        logic [31:0] expAddr;
        logic        expWrite;
        logic [3:0]  expStb;
        logic [31:0] expWdata;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic dv,
                                 input logic [31:0] da, input logic [31:0] dw,
                                 input logic [3:0] ds, input logic dwr);
        bus.ivalid = iv;
        bus.iaddr  = ia;
        bus.dvalid = dv;
        bus.daddr  = da;
        bus.dwdata = dw;
        bus.dwstb  = ds;
        bus.dwrite = dwr;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        bus.mready = 1'b0;
        bus.mrdata = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Transaction-level reference state for the randomized run
    bit          mBusy, mSideD, iReq, dReq, dWr, mr, prioD, prioReq, otherReq, winPrio;
    int          mWait, consec;
    logic [31:0] iA, dA, dW, rdat;
    logic [3:0]  dS;
    logic [31:0] expIw, expDw;
    int          grantSide [6];

    initial begin : watchdog
        #2_000_000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        bus.mready = 1'b0;
        bus.mrdata = '0;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h13,   1'b0, 32'h100,  1'b0, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 32'h40,   32'h0,        4'h3, 1'b0, 32'hA5A5, 1'b1, 32'h40,   1'b0, 4'h3, 32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,    1'b1, 32'h2000, 1'b1, 4'hF, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'h200, 1'b1, 32'h300,  32'h11,       4'h1, 1'b1, 32'h1,    1'b1, 32'h300,  1'b1, 4'h1, 32'h11};
        vecs[4] = '{1'b1, 32'h204, 1'b1, 32'h304,  32'h22,       4'h2, 1'b0, 32'h2,    1'b1, 32'h304,  1'b0, 4'h2, 32'h22};
        vecs[5] = '{1'b1, 32'h208, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h3,    1'b0, 32'h208,  1'b0, 4'hF, 32'h0};
        vecs[6] = '{1'b1, 32'h20C, 1'b1, 32'h308,  32'h33,       4'h4, 1'b1, 32'h4,    1'b1, 32'h308,  1'b1, 4'h4, 32'h33};

        // Reset state
        doReset();
        checkOutput("reset mvalid", bus.mvalid, 0);
        checkOutput("reset mwrite", bus.mwrite, 0);
        checkOutput("reset maddr", bus.maddr, 0);
        checkOutput("reset mwdata", bus.mwdata, 0);
        checkOutput("reset mwstb", bus.mwstb, 0);
        checkOutput("reset iready", bus.iready, 0);
        checkOutput("reset dready", bus.dready, 0);

        // Single zero-wait transactions from the vector table
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            bus.mready = 1'b0;
            checkOutput($sformatf("vec%0d idle mvalid", i), bus.mvalid, 0);
            applyStimulus(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dw, vecs[i].ds, vecs[i].dwr);
            @(negedge clock);
            checkOutput($sformatf("vec%0d mvalid", i), bus.mvalid, 1);
            checkOutput($sformatf("vec%0d maddr", i), bus.maddr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d mwrite", i), bus.mwrite, vecs[i].expWrite);
            checkOutput($sformatf("vec%0d mwstb", i), bus.mwstb, vecs[i].expStb);
            if (vecs[i].expD)
                checkOutput($sformatf("vec%0d mwdata", i), bus.mwdata, vecs[i].expWdata);
            bus.mready = 1'b1;
            bus.mrdata = vecs[i].rd;
            #1;
            checkOutput($sformatf("vec%0d iready", i), bus.iready, !vecs[i].expD);
            checkOutput($sformatf("vec%0d dready", i), bus.dready, vecs[i].expD);
            checkOutput($sformatf("vec%0d idata", i), bus.idata, vecs[i].rd);
            checkOutput($sformatf("vec%0d drdata", i), bus.drdata, vecs[i].rd);
            applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        end
        @(negedge clock);
        bus.mready = 1'b0;

        // Collision: the store goes first, the held fetch follows after one IDLE cycle
        doReset();
        applyStimulus(1'b1, 32'h400, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b1);
        @(negedge clock);
        checkOutput("coll D maddr", bus.maddr, 32'h2000);
        checkOutput("coll D mwrite", bus.mwrite, 1);
        checkOutput("coll D mwdata", bus.mwdata, 32'hDEADBEEF);
        bus.mready = 1'b1;
        #1;
        checkOutput("coll dready", bus.dready, 1);
        checkOutput("coll iready early", bus.iready, 0);
        bus.dvalid = 1'b0;
        @(negedge clock);
        bus.mready = 1'b0;
        checkOutput("coll idle gap", bus.mvalid, 0);
        @(negedge clock);
        checkOutput("coll I mvalid", bus.mvalid, 1);
        checkOutput("coll I maddr", bus.maddr, 32'h400);
        checkOutput("coll I mwrite", bus.mwrite, 0);
        checkOutput("coll I mwstb", bus.mwstb, 4'hF);
        bus.mready = 1'b1;
        #1;
        checkOutput("coll iready", bus.iready, 1);
        bus.ivalid = 1'b0;
        @(negedge clock);
        bus.mready = 1'b0;

        // Starvation: fetch held, data re-requested every IDLE -> D,D,D,D,I,D
        doReset();
        grantSide = '{1, 1, 1, 1, 0, 1};
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h600, '0, 4'hF, 1'b0);
        for (int g = 0; g < 6; g++) begin
            @(negedge clock);
            checkOutput($sformatf("starve g%0d mvalid", g), bus.mvalid, 1);
            checkOutput($sformatf("starve g%0d maddr", g), bus.maddr,
                        (grantSide[g] == 1) ? 32'h600 + 32'(g) : 32'h500);
            bus.mready = 1'b1;
            #1;
            checkOutput($sformatf("starve g%0d dready", g), bus.dready, 32'(grantSide[g]));
            if (grantSide[g] == 1)
                bus.dvalid = 1'b0;
            @(negedge clock);
            bus.mready = 1'b0;
            bus.dvalid = 1'b1;
            bus.daddr  = 32'h600 + 32'(g + 1);
        end
        @(negedge clock);
        bus.mready = 1'b1;
        #1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clock);
        bus.mready = 1'b0;

        // Wait states: memory answers on the fourth mvalid cycle
        doReset();
        applyStimulus(1'b1, 32'h700, 1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checkOutput($sformatf("wait k%0d mvalid", k), bus.mvalid, 1);
            checkOutput($sformatf("wait k%0d maddr", k), bus.maddr, 32'h700);
            checkOutput($sformatf("wait k%0d mwstb", k), bus.mwstb, 4'hF);
            checkOutput($sformatf("wait k%0d iready", k), bus.iready, 0);
        end
        bus.mready = 1'b1;
        bus.mrdata = 32'h5150;
        #1;
        checkOutput("wait iready", bus.iready, 1);
        checkOutput("wait idata", bus.idata, 32'h5150);
        bus.ivalid = 1'b0;
        @(negedge clock);
        bus.mready = 1'b0;
        checkOutput("wait back idle", bus.mvalid, 0);

        // Reset while a store is in flight
        applyStimulus(1'b0, '0, 1'b1, 32'h800, 32'h5, 4'hF, 1'b1);
        @(negedge clock);
        checkOutput("rst busy mvalid", bus.mvalid, 1);
        reset = 1'b1;
        @(negedge clock);
        bus.mready = 1'b1;
        #1;
        checkOutput("rst mvalid", bus.mvalid, 0);
        checkOutput("rst dready", bus.dready, 0);
        checkOutput("rst maddr", bus.maddr, 0);
        reset = 1'b0;
        bus.mready = 1'b0;
        bus.dvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checkOutput($sformatf("rst after k%0d mvalid", k), bus.mvalid, 0);
            checkOutput($sformatf("rst after k%0d dready", k), bus.dready, 0);
        end

`ifdef FWRISC_MEM_ARB_PERF_EN
        // Fetch stuck behind a 3-cycle data access
        doReset();
        applyStimulus(1'b1, 32'h900, 1'b1, 32'hA00, '0, 4'hF, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        bus.mready = 1'b1;
        #1;
        bus.dvalid = 1'b0;
        @(negedge clock);
        bus.mready = 1'b0;
        checkOutput("perf i_wait_cnt", i_wait_cnt, 4);
        checkOutput("perf d_wait_cnt", d_wait_cnt, 1);
        @(negedge clock);
        bus.mready = 1'b1;
        #1;
        bus.ivalid = 1'b0;
        @(negedge clock);
        bus.mready = 1'b0;
`endif

        // Randomized traffic against the transaction-level model
        doReset();
        mBusy = 0; mSideD = 0; mWait = 0; consec = 0; iReq = 0; dReq = 0;
        iA = '0; dA = '0; dW = '0; dS = '0; dWr = 0;
        expIw = '0; expDw = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            if (!iReq && $urandom_range(0, 2) != 0) begin
                iReq = 1; iA = $urandom;
            end
            if (!dReq && $urandom_range(0, 2) != 0) begin
                dReq = 1; dA = $urandom; dW = $urandom;
                dS = 4'($urandom_range(0, 15)); dWr = 1'($urandom_range(0, 1));
            end
            mr   = mBusy && (mWait == 0);
            rdat = $urandom;
            applyStimulus(iReq, iA, dReq, dA, dW, dS, dWr);
            bus.mready = mr;
            bus.mrdata = rdat;
            #1;
            checkOutput("rnd mvalid", bus.mvalid, mBusy);
            if (mBusy) begin
                checkOutput("rnd maddr", bus.maddr, mSideD ? dA : iA);
                checkOutput("rnd mwrite", bus.mwrite, mSideD ? dWr : 1'b0);
                checkOutput("rnd mwstb", bus.mwstb, mSideD ? dS : 4'hF);
                if (mSideD)
                    checkOutput("rnd mwdata", bus.mwdata, dW);
            end
            checkOutput("rnd iready", bus.iready, mr && !mSideD);
            checkOutput("rnd dready", bus.dready, mr && mSideD);
            checkOutput("rnd idata", bus.idata, rdat);
`ifdef FWRISC_MEM_ARB_PERF_EN
            checkOutput("rnd i_wait_cnt", i_wait_cnt, expIw);
            checkOutput("rnd d_wait_cnt", d_wait_cnt, expDw);
            if (iReq && !(mBusy && !mSideD)) expIw = expIw + 1;
            if (dReq && !(mBusy && mSideD))  expDw = expDw + 1;
`endif
            if (mBusy) begin
                if (mr) begin
                    mBusy = 0;
                    if (mSideD) dReq = 0; else iReq = 0;
                end else begin
                    mWait--;
                end
            end else if (iReq || dReq) begin
                prioD    = (DATA_PRIORITY != 0);
                prioReq  = prioD ? dReq : iReq;
                otherReq = prioD ? iReq : dReq;
                if (prioReq && otherReq) begin
                    if (consec >= MAX_CONSEC) begin
                        winPrio = 0; consec = 0;
                    end else begin
                        winPrio = 1; consec++;
                    end
                end else begin
                    winPrio = prioReq; consec = 0;
                end
                mSideD = winPrio ? prioD : !prioD;
                mBusy  = 1;
                mWait  = $urandom_range(0, 3);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
